// File: rtl/csel_sub_seq_if.sv
// csel_sub_seq_if
//   Operand/result handshake bundle for the iterative carry-select subtractor.
//   Parameters: width (bits per slice), nslices (slice count); N = width*nslices.
//   Signals:
//     in_valid   master->slave  operands a, b valid
//     in_ready   slave->master  subtractor can accept operands
//     a, b       master->slave  N-bit unsigned minuend / subtrahend
//     out_valid  slave->master  d and borrow_out valid
//     out_ready  master->slave  consumer accepts the result
//     d          slave->master  N-bit difference
//     borrow_out slave->master  1 when a < b (unsigned)
interface csel_sub_seq_if #(
  parameter int width   = 8,
  parameter int nslices = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [width*nslices-1:0]   a;
  logic [width*nslices-1:0]   b;
  logic                       out_valid;
  logic                       out_ready;
  logic [width*nslices-1:0]   d;
  logic                       borrow_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow_out
  );
endinterface

// File: rtl/csel_sub_seq.sv
// csel_sub_seq
//   Iterative carry-select subtractor: computes a - b over width*nslices bits,
//   one width-bit slice per cycle. Each slice is evaluated for both borrow-in
//   values and the registered borrow from the previous slice picks one.
//   Optional build macro: CSEL_SUB_SAT_EN -- when defined, a final borrow of 1
//   forces d to 0 on entry to DONE (borrow_out still reads 1).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    csel_sub_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/d/borrow_out)
module csel_sub_seq #(
  parameter int width   = 8,
  parameter int nslices = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  csel_sub_seq_if.slave   bus
);
  localparam int N  = width * nslices;
  localparam int IW = (nslices > 1) ? $clog2(nslices) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(nslices - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_n;
  logic [N-1:0]    a_r, b_r, d_r;
  logic [IW-1:0]   idx_r;
  logic            borrow_r;
  logic            borrow_out_r;
  logic            in_ready_r;
  logic            out_valid_r;

  logic [width-1:0] a_slice_s, b_slice_s;
  logic [width:0]   d0_s, d1_s, sel_s;
  logic             borrow_n_s;
  logic             last_s;
  logic [N-1:0]     d_merge_s, d_calc_s;

  // Slice datapath, result merge and next-state decode.
  always_comb begin
    state_n   = state_r;
    a_slice_s = a_r[int'(idx_r)*width +: width];
    b_slice_s = b_r[int'(idx_r)*width +: width];
    // Both borrow-in hypotheses; a carry out of a + ~b (+1) means no borrow.
    d0_s       = {1'b0, a_slice_s} + {1'b0, ~b_slice_s} + {{width{1'b0}}, 1'b1};
    d1_s       = {1'b0, a_slice_s} + {1'b0, ~b_slice_s};
    sel_s      = borrow_r ? d1_s : d0_s;
    borrow_n_s = ~sel_s[width];
    last_s     = (idx_r == LAST_IDX);
    d_merge_s  = d_r;
    d_merge_s[int'(idx_r)*width +: width] = sel_s[width-1:0];
`ifdef CSEL_SUB_SAT_EN
    // Clamp to zero only once the whole-word borrow is known.
    d_calc_s = (last_s && borrow_n_s) ? {N{1'b0}} : d_merge_s;
`else
    d_calc_s = d_merge_s;
`endif
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, operand, slice-index, borrow and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      a_r          <= {N{1'b0}};
      b_r          <= {N{1'b0}};
      d_r          <= {N{1'b0}};
      idx_r        <= {IW{1'b0}};
      borrow_r     <= 1'b0;
      borrow_out_r <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      // Handshake flags are registered copies of the next-state decode.
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            idx_r    <= {IW{1'b0}};
            borrow_r <= 1'b0;
          end
        end
        CALC: begin
          d_r      <= d_calc_s;
          borrow_r <= borrow_n_s;
          if (last_s) begin
            borrow_out_r <= borrow_n_s;
          end else begin
            idx_r <= idx_r + ONE_IDX;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.d          = d_r;
  assign bus.borrow_out = borrow_out_r;
endmodule

// File: tb/tb_csel_sub_seq.sv
// tb_csel_sub_seq
//   Self-checking bench for csel_sub_seq (width=8, nslices=4): directed vector
//   table, hand-written reset/backpressure sequences, and random operands
//   compared against a plain-arithmetic reference model.
module tb_csel_sub_seq;
  localparam int W  = 8;
  localparam int NS = 4;
  localparam int N  = W * NS;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  csel_sub_seq_if #(.width(W), .nslices(NS)) bus ();

  csel_sub_seq #(.width(W), .nslices(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_d;
    logic         exp_bo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference: unsigned subtraction modulo 2^N, borrow when a < b.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] d, output logic bo);
    bo = (a < b);
    d  = a - b;
`ifdef CSEL_SUB_SAT_EN
    if (bo) d = '0;
`endif
  endfunction

  // Issue one operation, check latency and result, then consume it after `hold` cycles.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_d, input logic exp_bo,
                        input int hold, input string name);
    int cycles;
    @(negedge clk);
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;  // operands may change after acceptance
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk({name, "_latency"}, cycles, 32'd4);
    for (int i = 0; i < hold; i++) @(negedge clk);
    chk({name, "_d"}, bus.d, exp_d);
    chk({name, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, exp_bo});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [N-1:0] ed, d_hold;
    logic         eb;
    int           ov_seen;
    total = 0; passed = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;

    vecs[0] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
`ifdef CSEL_SUB_SAT_EN
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
`else
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
`endif
    vecs[2] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};

    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_d", bus.d, 32'd0);
    chk("rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_bo, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 10 cycles, new operands ignored meanwhile.
    model(32'h1234_5678, 32'h0000_0001, ed, eb);
    @(negedge clk);
    bus.a = 32'h1234_5678; bus.b = 32'h0000_0001; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_out_valid_start", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0009; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_d", bus.d, ed);
      chk("bp_borrow", {31'd0, bus.borrow_out}, {31'd0, eb});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_d_stable", bus.d, ed);
    @(negedge clk);
    chk("bp_no_restart", {31'd0, bus.in_ready}, 32'd1);

    // Async reset mid-cycle while a result sits in DONE.
    @(negedge clk);
    bus.a = 32'h0000_00F0; bus.b = 32'h0000_0010; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_d", bus.d, 32'd0);
    chk("async_rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the 2nd CALC cycle: operation is discarded, no result pulse.
    @(negedge clk);
    bus.a = 32'h0000_0000; bus.b = 32'h0000_0007; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_calc_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_calc_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("mid_calc_no_result", ov_seen, 32'd0);
    run_op(32'd5, 32'd3, 32'd2, 1'b0, 0, "post_rst");

    // Random operands against the arithmetic model, random consumer delay.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ra + N'($urandom_range(0, 3)) : $urandom;
      model(ra, rb, ed, eb);
      run_op(ra, rb, ed, eb, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
